// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: fetch FSM states, canonical NOP and the fetch queue entry.
package riscv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN,
        FAULT_PEND,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decoder handshake.
interface fetch_unit_if;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic        dec_misalign_o;

    modport master (
        output imem_addr_o,
        input  imem_data_i,
        input  redirect_i,
        input  redirect_pc_i,
        output dec_valid_o,
        input  dec_ready_i,
        output dec_instr_o,
        output dec_pc_o,
        output dec_misalign_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_data_i,
        output redirect_i,
        output redirect_pc_i,
        input  dec_valid_o,
        output dec_ready_i,
        input  dec_instr_o,
        input  dec_pc_o,
        input  dec_misalign_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetch entries; slot0 is always the head, so a pop shifts slot1 down.
module fetch_queue
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic         load,
    input  fetch_entry_t push_entry,
    input  fetch_entry_t load_entry,
    output logic [1:0]   count,
    output fetch_entry_t head
);
    fetch_entry_t slot0;
    fetch_entry_t slot1;

    // load replaces the whole queue with one entry, so it dominates flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 2'd0;
        else if (load)
            count <= 2'd1;
        else if (flush)
            count <= 2'd0;
        else if (push && !pop)
            count <= count + 2'd1;
        else if (pop && !push)
            count <= count - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            slot0 <= load_entry;
        end else if (!flush) begin
            if (pop) begin
                slot0 <= (push && count == 2'd1) ? push_entry : slot1;
                if (push)
                    slot1 <= push_entry;
            end else if (push) begin
                if (count == 2'd0)
                    slot0 <= push_entry;
                else
                    slot1 <= push_entry;
            end
        end
    end

    assign head = (count == 2'd0) ? '0 : slot0;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, queues (pc, instr) pairs for decode, handles redirects and misaligned targets.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = RV_NOP
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_unit_if.master bus
);
    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    fetch_entry_t load_entry;
    logic         valid;
    logic         aligned;
    logic         push;
    logic         pop;
    logic         flush;
    logic         load;

    assign valid      = (count != 2'd0);
    assign aligned    = (bus.redirect_pc_i[1:0] == 2'b00);
    assign push_entry = {fetch_pc, bus.imem_data_i, 1'b0};
    assign load_entry = {bus.redirect_pc_i, NOP_INSTR, 1'b1};

    // A redirect discards whatever head is on offer, so it also blocks the pop
    always_comb begin
        state_next = state;
        pop        = valid & bus.dec_ready_i & ~bus.redirect_i;
        push       = 1'b0;
        flush      = 1'b0;
        load       = 1'b0;
        if (bus.redirect_i) begin
            flush      = aligned;
            load       = ~aligned;
            state_next = aligned ? RUN : FAULT_PEND;
        end else begin
            case (state)
                RUN:        push = (count != 2'd2) | pop;
                FAULT_PEND: if (pop) state_next = HALT;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= RUN;
        else
            state <= state_next;
    end

    // A misaligned redirect leaves fetch_pc where it was; only HALT exit via a new redirect moves it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            fetch_pc <= RESET_PC;
        else if (bus.redirect_i && aligned)
            fetch_pc <= bus.redirect_pc_i;
        else if (push)
            fetch_pc <= fetch_pc + 32'd4;
    end

    fetch_queue u_queue (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .load       (load),
        .push_entry (push_entry),
        .load_entry (load_entry),
        .count      (count),
        .head       (head)
    );

    assign bus.imem_addr_o    = fetch_pc;
    assign bus.dec_valid_o    = valid;
    assign bus.dec_instr_o    = head.instr;
    assign bus.dec_pc_o       = head.pc;
    assign bus.dec_misalign_o = head.misalign;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected entries queued by stimulus, consumed by a negedge monitor.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic clk;
    logic rst;
    logic rst2;
    int   total;
    int   bad;
    logic [31:0] mem [1024];
    fetch_entry_t exp_q [$];

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk_i (clk),
        .rst_i (rst2),
        .bus   (bus2.master)
    );

    function automatic logic [31:0] imem_read(input logic [31:0] addr);
        if (addr < 32'd4096)
            return mem[addr[11:2]];
        return 32'h0;
    endfunction

    assign bus.imem_data_i  = imem_read(bus.imem_addr_o);
    assign bus2.imem_data_i = imem_read(bus2.imem_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic mis);
        exp_q.push_back({pc, instr, mis});
    endtask

    // Holds ready high for n cycles; the head must be valid at each of them
    task automatic drain(input int n);
        bus.dec_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", 64'(bus.dec_valid_o), 64'd1);
            step();
        end
        bus.dec_ready_i = 1'b0;
    endtask

    task automatic monitor();
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.dec_valid_o && bus.dec_ready_i && !bus.redirect_i) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pc", 64'(bus.dec_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc_instr", {bus.dec_pc_o, bus.dec_instr_o}, {e.pc, e.instr});
                    chk("sb_misalign", 64'(bus.dec_misalign_o), 64'(e.misalign));
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++)
            mem[i] = 32'hC0DE_0000 | 32'(i);
        rst                = 1'b1;
        rst2               = 1'b1;
        bus.redirect_i     = 1'b0;
        bus.redirect_pc_i  = 32'h0;
        bus.dec_ready_i    = 1'b0;
        bus2.redirect_i    = 1'b0;
        bus2.redirect_pc_i = 32'h0;
        bus2.dec_ready_i   = 1'b0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog");
            end
        join_none

        step();
        step();
        chk("reset_valid", 64'(bus.dec_valid_o), 64'd0);
        chk("reset_addr", 64'(bus.imem_addr_o), 64'd0);
        chk("reset_head", {bus.dec_pc_o, bus.dec_instr_o}, 64'd0);
        chk("reset_misalign", 64'(bus.dec_misalign_o), 64'd0);

        // Streaming from reset with ready held high
        expect_entry(32'h0, 32'hC0DE_0000, 1'b0);
        expect_entry(32'h4, 32'hC0DE_0001, 1'b0);
        expect_entry(32'h8, 32'hC0DE_0002, 1'b0);
        expect_entry(32'hC, 32'hC0DE_0003, 1'b0);
        bus.dec_ready_i = 1'b1;
        rst = 1'b0;
        step();
        chk("first_valid", 64'(bus.dec_valid_o), 64'd1);
        chk("first_pc", 64'(bus.dec_pc_o), 64'd0);
        drain(4);

        // Backpressure: queue fills, fetch address parks at 8
        rst = 1'b1;
        #1;
        chk("rst_valid_low", 64'(bus.dec_valid_o), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("bp_first_valid", 64'(bus.dec_valid_o), 64'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("bp_addr_hold", 64'(bus.imem_addr_o), 64'h8);
            step();
        end
        chk("bp_head_pc", 64'(bus.dec_pc_o), 64'h0);
        expect_entry(32'h0, 32'hC0DE_0000, 1'b0);
        expect_entry(32'h4, 32'hC0DE_0001, 1'b0);
        expect_entry(32'h8, 32'hC0DE_0002, 1'b0);
        drain(3);

        // Redirect on a full queue with ready high: queued entries are dropped
        expect_entry(32'h100, 32'hC0DE_0040, 1'b0);
        bus.dec_ready_i   = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h100;
        step();
        bus.redirect_i  = 1'b0;
        bus.dec_ready_i = 1'b0;
        chk("redir_valid_low", 64'(bus.dec_valid_o), 64'd0);
        chk("redir_addr", 64'(bus.imem_addr_o), 64'h100);
        step();
        chk("redir_head_valid", 64'(bus.dec_valid_o), 64'd1);
        chk("redir_head_pc", 64'(bus.dec_pc_o), 64'h100);
        drain(1);

        // Misaligned target: fault entry, then HALT with the fetch address frozen
        expect_entry(32'h102, 32'h0000_0013, 1'b1);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h102;
        step();
        bus.redirect_i = 1'b0;
        chk("fault_valid", 64'(bus.dec_valid_o), 64'd1);
        chk("fault_head", {bus.dec_pc_o, bus.dec_instr_o}, {32'h102, 32'h13});
        chk("fault_misalign", 64'(bus.dec_misalign_o), 64'd1);
        chk("fault_addr", 64'(bus.imem_addr_o), 64'h108);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("fault_hold_valid", 64'(bus.dec_valid_o), 64'd1);
            chk("fault_hold_addr", 64'(bus.imem_addr_o), 64'h108);
        end
        drain(1);
        bus.dec_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("halt_valid", 64'(bus.dec_valid_o), 64'd0);
            chk("halt_addr", 64'(bus.imem_addr_o), 64'h108);
            step();
        end
        bus.dec_ready_i = 1'b0;
        expect_entry(32'h200, 32'hC0DE_0080, 1'b0);
        expect_entry(32'h204, 32'hC0DE_0081, 1'b0);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h200;
        step();
        bus.redirect_i = 1'b0;
        chk("restart_addr", 64'(bus.imem_addr_o), 64'h200);
        step();
        chk("restart_pc", 64'(bus.dec_pc_o), 64'h200);
        drain(2);

        // Running off the end of memory yields zero words
        expect_entry(32'hFFC, 32'hC0DE_03FF, 1'b0);
        expect_entry(32'h1000, 32'h0, 1'b0);
        expect_entry(32'h1004, 32'h0, 1'b0);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFC;
        step();
        bus.redirect_i = 1'b0;
        step();
        chk("edge_pc", 64'(bus.dec_pc_o), 64'hFFC);
        drain(3);

        // Asynchronous reset with a full queue
        step();
        step();
        step();
        chk("full_valid", 64'(bus.dec_valid_o), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", 64'(bus.dec_valid_o), 64'd0);
        chk("async_addr", 64'(bus.imem_addr_o), 64'h0);
        chk("async_pc", 64'(bus.dec_pc_o), 64'h0);
        step();
        expect_entry(32'h0, 32'hC0DE_0000, 1'b0);
        expect_entry(32'h4, 32'hC0DE_0001, 1'b0);
        expect_entry(32'h8, 32'hC0DE_0002, 1'b0);
        rst = 1'b0;
        step();
        chk("rerun_valid", 64'(bus.dec_valid_o), 64'd1);
        chk("rerun_pc", 64'(bus.dec_pc_o), 64'h0);
        drain(3);

        // PC wrap from the top of the address space
        rst2 = 1'b0;
        step();
        chk("wrap_valid", 64'(bus2.dec_valid_o), 64'd1);
        chk("wrap_head", {bus2.dec_pc_o, bus2.dec_instr_o}, {32'hFFFF_FFFC, 32'h0});
        chk("wrap_addr", 64'(bus2.imem_addr_o), 64'h0);
        bus2.dec_ready_i = 1'b1;
        step();
        bus2.dec_ready_i = 1'b0;
        chk("wrap_next_head", {bus2.dec_pc_o, bus2.dec_instr_o}, {32'h0, 32'hC0DE_0000});

        step();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
